// File: rtl/poscalc_ds_if.sv
// poscalc_ds_if: amplitude-in / position-out bus of the delta-over-sum calculator.
interface poscalc_ds_if #(
    parameter int DATAIN_WIDTH  = 16,
    parameter int DATAOUT_WIDTH = 16
);
    logic [DATAIN_WIDTH-1:0]         data_a_i;
    logic [DATAIN_WIDTH-1:0]         data_b_i;
    logic [DATAIN_WIDTH-1:0]         data_c_i;
    logic [DATAIN_WIDTH-1:0]         data_d_i;
    logic                            val_i;
    logic                            ready_o;
    logic signed [DATAOUT_WIDTH-1:0] data_x_o;
    logic signed [DATAOUT_WIDTH-1:0] data_y_o;
    logic [DATAIN_WIDTH+1:0]         data_sum_o;
    logic                            val_o;
    logic                            div0_o;
    logic                            ovf_o;

    modport master (
        output data_a_i, data_b_i, data_c_i, data_d_i, val_i,
        input  ready_o, data_x_o, data_y_o, data_sum_o, val_o, div0_o, ovf_o
    );

    modport slave (
        input  data_a_i, data_b_i, data_c_i, data_d_i, val_i,
        output ready_o, data_x_o, data_y_o, data_sum_o, val_o, div0_o, ovf_o
    );
endinterface

// File: rtl/poscalc_ds.sv
// poscalc_ds: X/Y beam position as (delta/sum) in Q1.F via parallel restoring division.
module poscalc_ds #(
    parameter int DATAIN_WIDTH  = 16,
    parameter int DATAOUT_WIDTH = 16
) (
    input logic         clk_i,
    input logic         rst_n_i,
    poscalc_ds_if.slave bus
);
    localparam int W  = DATAIN_WIDTH;
    localparam int SW = W + 2;
    localparam int DW = W + 3;
    localparam int F  = DATAOUT_WIDTH - 1;
    localparam int CW = $clog2(F + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, OUT} state_t;

    state_t                   state;
    logic [W-1:0]             a_q, b_q, c_q, d_q;
    logic [SW-1:0]            sum_q;
    logic [DW-1:0]            rx_q, ry_q;
    logic [F-1:0]             qx_q, qy_q;
    logic                     neg_x_q, neg_y_q, sat_x_q, sat_y_q;
    logic [CW-1:0]            cnt_q;
    logic [SW-1:0]            sum_c, mag_x_c, mag_y_c;
    logic signed [DW-1:0]     dx_c, dy_c;
    logic [DW-1:0]            rx2_c, ry2_c;
    logic                     ge_x_c, ge_y_c;
    logic [F-1:0]             fx_c, fy_c;
    logic [DATAOUT_WIDTH-1:0] ox_c, oy_c;

    always_comb begin
        sum_c   = SW'(a_q) + SW'(b_q) + SW'(c_q) + SW'(d_q);
        dx_c    = $signed(DW'(a_q) + DW'(d_q) - DW'(b_q) - DW'(c_q));
        dy_c    = $signed(DW'(a_q) + DW'(b_q) - DW'(c_q) - DW'(d_q));
        mag_x_c = SW'(dx_c[DW-1] ? -dx_c : dx_c);
        mag_y_c = SW'(dy_c[DW-1] ? -dy_c : dy_c);
        rx2_c   = rx_q << 1;
        ry2_c   = ry_q << 1;
        ge_x_c  = rx2_c >= DW'(sum_q);
        ge_y_c  = ry2_c >= DW'(sum_q);
        // a zero sum forces zero position, ahead of the |delta|>=sum saturation it also triggers
        fx_c    = sum_q == '0 ? '0 : sat_x_q ? '1 : qx_q;
        fy_c    = sum_q == '0 ? '0 : sat_y_q ? '1 : qy_q;
        ox_c    = {1'b0, fx_c};
        oy_c    = {1'b0, fy_c};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            bus.ready_o    <= 1'b1;
            bus.val_o      <= 1'b0;
            bus.data_x_o   <= '0;
            bus.data_y_o   <= '0;
            bus.data_sum_o <= '0;
            bus.div0_o     <= 1'b0;
            bus.ovf_o      <= 1'b0;
        end else begin
            bus.val_o <= 1'b0;
            if (bus.val_i && !bus.ready_o)
                bus.ovf_o <= 1'b1;
            case (state)
                IDLE: if (bus.val_i) begin
                    a_q         <= bus.data_a_i;
                    b_q         <= bus.data_b_i;
                    c_q         <= bus.data_c_i;
                    d_q         <= bus.data_d_i;
                    bus.ready_o <= 1'b0;
                    state       <= LOAD;
                end
                LOAD: begin
                    sum_q   <= sum_c;
                    rx_q    <= DW'(mag_x_c);
                    ry_q    <= DW'(mag_y_c);
                    neg_x_q <= dx_c[DW-1];
                    neg_y_q <= dy_c[DW-1];
                    sat_x_q <= mag_x_c >= sum_c;
                    sat_y_q <= mag_y_c >= sum_c;
                    cnt_q   <= '0;
                    state   <= DIV;
                end
                DIV: begin
                    rx_q  <= ge_x_c ? rx2_c - DW'(sum_q) : rx2_c;
                    ry_q  <= ge_y_c ? ry2_c - DW'(sum_q) : ry2_c;
                    qx_q  <= {qx_q[F-2:0], ge_x_c};
                    qy_q  <= {qy_q[F-2:0], ge_y_c};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(F - 1))
                        state <= OUT;
                end
                OUT: begin
                    bus.data_x_o   <= neg_x_q ? -ox_c : ox_c;
                    bus.data_y_o   <= neg_y_q ? -oy_c : oy_c;
                    bus.data_sum_o <= sum_q;
                    bus.div0_o     <= sum_q == '0;
                    bus.val_o      <= 1'b1;
                    bus.ready_o    <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_poscalc_ds.sv
// tb_poscalc_ds: scoreboard bench for poscalc_ds; expected results come from an integer division model.
module tb_poscalc_ds;
    localparam int F   = 15;
    localparam int LAT = 18;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [17:0]        sum;
        logic               div0;
    } res_t;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    int   cyc     = 0;
    int   passed  = 0;
    int   total   = 0;
    res_t exp_q[$];
    res_t obs_q[$];
    int   exp_cyc[$];
    int   obs_cyc[$];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    poscalc_ds_if bus ();

    poscalc_ds dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bus    (bus)
    );

    always @(negedge clk_i)
        if (bus.val_o === 1'b1) begin
            obs_q.push_back({bus.data_x_o, bus.data_y_o, bus.data_sum_o, bus.div0_o});
            obs_cyc.push_back(cyc);
        end

    function automatic logic signed [15:0] axis(input longint dv, input longint s);
        longint m = dv < 0 ? -dv : dv;
        longint q = m >= s ? (64'd1 << F) - 1 : (m << F) / s;
        return 16'(dv < 0 ? -q : q);
    endfunction

    function automatic res_t model(input longint a, input longint b, input longint c, input longint d);
        res_t   r;
        longint s = a + b + c + d;
        r.sum  = 18'(s);
        r.div0 = s == 0;
        r.x    = s == 0 ? 16'sd0 : axis((a + d) - (b + c), s);
        r.y    = s == 0 ? 16'sd0 : axis((a + b) - (c + d), s);
        return r;
    endfunction

    task automatic drive(input int a, input int b, input int c, input int d, input bit acc);
        @(posedge clk_i);
        #1;
        bus.data_a_i = 16'(a);
        bus.data_b_i = 16'(b);
        bus.data_c_i = 16'(c);
        bus.data_d_i = 16'(d);
        bus.val_i    = 1'b1;
        if (acc) begin
            exp_q.push_back(model(a, b, c, d));
            exp_cyc.push_back(cyc);
        end
        @(posedge clk_i);
        #1;
        bus.val_i = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_i);
            ok = obs_q.size() > 0;
        end
    endtask

    task automatic test_reset();
        logic [53:0] got;
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        got = {bus.ready_o, bus.val_o, bus.div0_o, bus.ovf_o, bus.data_x_o, bus.data_y_o, bus.data_sum_o};
        total++;
        if (got !== {1'b1, 53'd0}) $display("FAIL reset_state: got %h want %h", got, {1'b1, 53'd0});
        else passed++;
        #1 rst_n_i = 1'b1;
    endtask

    task automatic test_function();
        int   tbl[4][4] = '{'{1000, 1000, 1000, 1000}, '{3000, 1000, 1000, 1000},
                            '{0, 1000, 0, 0}, '{65535, 0, 65535, 65535}};
        bit   ok;
        res_t e, o;
        int   ec, oc;
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], 1'b1);
            wait_out(ok);
            total++;
            if (!ok) begin
                $display("FAIL func%0d_timeout: no val_o within 40 cycles", i);
                exp_q.delete();
                exp_cyc.delete();
            end else begin
                e = exp_q.pop_front(); ec = exp_cyc.pop_front();
                o = obs_q.pop_front(); oc = obs_cyc.pop_front();
                if (o !== e) $display("FAIL func%0d_result: got x=%0d y=%0d sum=%0d div0=%b want x=%0d y=%0d sum=%0d div0=%b",
                                      i, o.x, o.y, o.sum, o.div0, e.x, e.y, e.sum, e.div0);
                else passed++;
                total++;
                if (oc - ec !== LAT) $display("FAIL func%0d_latency: got %0d want %0d", i, oc - ec, LAT);
                else passed++;
            end
        end
    endtask

    task automatic test_div0();
        int   tbl[2][4] = '{'{0, 0, 0, 0}, '{100, 200, 300, 400}};
        bit   ok;
        res_t e, o;
        for (int i = 0; i < 2; i++) begin
            drive(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], 1'b1);
            wait_out(ok);
            total++;
            if (!ok) begin
                $display("FAIL div0_%0d_timeout: no val_o within 40 cycles", i);
                exp_q.delete();
                exp_cyc.delete();
            end else begin
                e = exp_q.pop_front(); void'(exp_cyc.pop_front());
                o = obs_q.pop_front(); void'(obs_cyc.pop_front());
                if (o !== e) $display("FAIL div0_%0d_result: got x=%0d y=%0d sum=%0d div0=%b want x=%0d y=%0d sum=%0d div0=%b",
                                      i, o.x, o.y, o.sum, o.div0, e.x, e.y, e.sum, e.div0);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        res_t e, o;
        drive(1000, 2000, 3000, 4000, 1'b1);
        repeat (3) @(posedge clk_i);
        drive(9, 9, 9, 9, 1'b0);
        total++;
        if (bus.ovf_o !== 1'b1) $display("FAIL bp_ovf_set: got %b want 1", bus.ovf_o);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            wait_out(ok);
            total++;
            if (!ok) begin
                $display("FAIL bp%0d_timeout: no val_o within 40 cycles", i);
                exp_q.delete();
                exp_cyc.delete();
            end else begin
                e = exp_q.pop_front(); void'(exp_cyc.pop_front());
                o = obs_q.pop_front(); void'(obs_cyc.pop_front());
                if (o !== e) $display("FAIL bp%0d_result: got x=%0d y=%0d sum=%0d want x=%0d y=%0d sum=%0d",
                                      i, o.x, o.y, o.sum, e.x, e.y, e.sum);
                else passed++;
            end
            if (i == 0) drive(500, 6000, 70, 8, 1'b1);
        end
        repeat (5) @(negedge clk_i);
        total++;
        if (obs_q.size() !== 0) $display("FAIL bp_extra_val_o: got %0d extra results want 0", obs_q.size());
        else passed++;
        total++;
        if (bus.ovf_o !== 1'b1) $display("FAIL bp_ovf_sticky: got %b want 1", bus.ovf_o);
        else passed++;
    endtask

    task automatic test_reset_mid_div();
        bit          ok;
        logic [53:0] got;
        res_t        e, o;
        drive(4000, 100, 2500, 7, 1'b1);
        repeat (8) @(posedge clk_i);
        #1 rst_n_i = 1'b0;
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        exp_q.delete();
        exp_cyc.delete();
        @(negedge clk_i);
        got = {bus.ready_o, bus.val_o, bus.div0_o, bus.ovf_o, bus.data_x_o, bus.data_y_o, bus.data_sum_o};
        total++;
        if (got !== {1'b1, 53'd0}) $display("FAIL abort_state: got %h want %h", got, {1'b1, 53'd0});
        else passed++;
        repeat (20) @(negedge clk_i);
        total++;
        if (obs_q.size() !== 0) $display("FAIL abort_no_val_o: got %0d results want 0", obs_q.size());
        else passed++;
        obs_q.delete();
        obs_cyc.delete();
        drive(4000, 100, 2500, 7, 1'b1);
        wait_out(ok);
        total++;
        if (!ok) $display("FAIL abort_resume_timeout: no val_o within 40 cycles");
        else begin
            e = exp_q.pop_front(); void'(exp_cyc.pop_front());
            o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            if (o !== e) $display("FAIL abort_resume_result: got x=%0d y=%0d sum=%0d want x=%0d y=%0d sum=%0d",
                                  o.x, o.y, o.sum, e.x, e.y, e.sum);
            else passed++;
        end
    endtask

    initial begin
        bus.data_a_i = '0;
        bus.data_b_i = '0;
        bus.data_c_i = '0;
        bus.data_d_i = '0;
        bus.val_i    = 1'b0;
        test_reset();
        test_function();
        test_div0();
        test_back_to_back();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
